// File: rtl/bank_ram_pkg.sv
// Shared types and constants for the bank RAM burst master and its read-return FIFO.
package bank_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } burst_state_e;

   localparam int BURST_RD_FIFO_DEPTH = 4;
   localparam int BURST_RD_CNT_W      = $clog2(BURST_RD_FIFO_DEPTH + 1);
   localparam int BURST_RD_PTR_W      = $clog2(BURST_RD_FIFO_DEPTH);

endpackage

// File: rtl/ram_if.sv
// Single-port bank RAM port: 1-cycle read latency, rdata held between reads.
interface ram_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) ();
   logic                  en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output en, output we, output addr, output wdata, input rdata);
   modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/burst_rd_fifo.sv
// Small synchronous FIFO that absorbs read data returning from the RAM pipeline.
module burst_rd_fifo
   import bank_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [DATA_WIDTH-1:0]     push_data,
   input  logic                      pop,
   output logic [BURST_RD_CNT_W-1:0] count,
   output logic [DATA_WIDTH-1:0]     head
);

   logic [DATA_WIDTH-1:0]     store [BURST_RD_FIFO_DEPTH];
   logic [BURST_RD_PTR_W-1:0] wr_ptr;
   logic [BURST_RD_PTR_W-1:0] rd_ptr;
   logic                      do_push;
   logic                      do_pop;

   assign do_push = push && (count != BURST_RD_CNT_W'(BURST_RD_FIFO_DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = store[rd_ptr];

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the count gates visibility, so stale words are never observed.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bank_ram_burst_master.sv
// Command-driven burst initiator for a bank RAM: streams writes in, streams reads out with backpressure.
module bank_ram_burst_master
   import bank_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  done,
   ram_if.master                 ram
);

   localparam int OCC_W = BURST_RD_CNT_W + 1;

   burst_state_e              state;
   burst_state_e              next_state;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [LEN_WIDTH-1:0]      remaining_q;
   logic                      ram_en_q;
   logic                      ram_we_q;
   logic [ADDR_WIDTH-1:0]     ram_addr_q;
   logic [DATA_WIDTH-1:0]     ram_wdata_q;
   logic [1:0]                issue_sr;
   logic                      wr_done_q;
   logic                      done_q;
   logic [BURST_RD_CNT_W-1:0] fifo_count;
   logic [DATA_WIDTH-1:0]     fifo_head;

   logic                      cmd_fire;
   logic                      wr_fire;
   logic                      rd_issue;
   logic                      rd_pop;
   logic                      drained;
   logic                      last_word;
   logic [1:0]                inflight;
   logic [OCC_W-1:0]          occupancy;

   assign cmd_ready = (state == IDLE) && !rst;
   assign wr_ready  = (state == WRITE);
   assign rd_valid  = (fifo_count != '0);
   assign rd_data   = fifo_head;
   assign done      = done_q;

   assign ram.en    = ram_en_q;
   assign ram.we    = ram_we_q;
   assign ram.addr  = ram_addr_q;
   assign ram.wdata = ram_wdata_q;

   // Reads are tracked by issue position, not by rdata changing: the RAM holds rdata between reads.
   assign inflight  = {1'b0, issue_sr[0]} + {1'b0, issue_sr[1]};
   assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight);

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      cmd_fire   = cmd_valid && cmd_ready;
      wr_fire    = (state == WRITE) && wr_valid;
      rd_issue   = (state == READ) && (remaining_q != '0)
                   && (occupancy < OCC_W'(BURST_RD_FIFO_DEPTH));
      rd_pop     = rd_valid && rd_ready;
      last_word  = (remaining_q == LEN_WIDTH'(1));
      drained    = (inflight == 2'd0)
                   && ((fifo_count == '0) || ((fifo_count == BURST_RD_CNT_W'(1)) && rd_pop));
      next_state = state;
      case (state)
         IDLE:  if (cmd_fire && (cmd_len != '0)) next_state = cmd_write ? WRITE : READ;
         WRITE: if (wr_fire && last_word) next_state = IDLE;
         READ:  if ((remaining_q == '0) || (rd_issue && last_word)) next_state = DRAIN;
         DRAIN: if (drained) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         issue_sr    <= '0;
         wr_done_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state     <= next_state;
         ram_en_q  <= 1'b0;
         ram_we_q  <= 1'b0;
         issue_sr  <= {issue_sr[0], rd_issue};
         wr_done_q <= wr_fire && last_word;
         // Write completion is reported once the final RAM write has actually taken place.
         done_q    <= (cmd_fire && (cmd_len == '0)) || wr_done_q || ((state == DRAIN) && drained);
         if (cmd_fire) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
         end
         if (wr_fire || rd_issue) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= wr_fire;
            ram_addr_q  <= addr_q;
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
         end
         if (wr_fire) ram_wdata_q <= wr_data;
      end
   end

   burst_rd_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (issue_sr[1]),
      .push_data(ram.rdata),
      .pop      (rd_pop),
      .count    (fifo_count),
      .head     (fifo_head)
   );

endmodule

// File: tb/tb_bank_ram_burst_master.sv
// Directed bench for bank_ram_burst_master: behavioural RAM, read scoreboard, latency checks.
module tb_bank_ram_burst_master;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int LW = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          done;

   ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

   bank_ram_burst_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .LEN_WIDTH (LW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .done     (done),
      .ram      (ram_bus)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: 1-cycle read latency, rdata held until the next read.
   logic [DW-1:0] mem     [2**AW];
   logic [DW-1:0] ref_mem [2**AW];

   always @(posedge clk) begin
      if (ram_bus.en) begin
         if (ram_bus.we) mem[ram_bus.addr] <= ram_bus.wdata;
         else            ram_bus.rdata     <= mem[ram_bus.addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passes = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Monitor state, sampled on the falling edge.
   int            wr_en_cnt, rd_issue_cnt, done_cnt, pops;
   int            first_wr_cyc, last_wr_cyc, done_cyc;
   int            first_rdv_cyc, first_pop_cyc, last_pop_cyc, max_out;
   int            cmd_cyc;
   logic [AW-1:0] wr_addr_log [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] wq [$];

   task automatic clear_stats();
      wr_en_cnt = 0; rd_issue_cnt = 0; done_cnt = 0; pops = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
      first_rdv_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; max_out = 0;
      wr_addr_log.delete();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_bus.en && ram_bus.we) begin
            if (wr_en_cnt == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_en_cnt++;
            wr_addr_log.push_back(ram_bus.addr);
         end
         if (ram_bus.en && !ram_bus.we) rd_issue_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_valid && first_rdv_cyc < 0) first_rdv_cyc = cyc;
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("rd_unexpected_word", 64'd1, 64'd0);
            else                   check("rd_data", rd_data, exp_q.pop_front());
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pops++;
         end
         if (rd_issue_cnt - pops > max_out) max_out = rd_issue_cnt - pops;
      end
   end

   task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] n);
      int k;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      if (k == 50) check("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_write(input logic [AW-1:0] a, input int n);
      logic [AW-1:0] ai;
      int            t;
      clear_stats();
      wr_valid = 1'b1;
      wr_data  = wq[0];
      issue_cmd(1'b1, a, LW'(n));
      for (int i = 0; i < n; i++) begin
         for (t = 0; t < 50; t++) begin
            if (wr_ready) break;
            @(negedge clk);
         end
         if (t == 50) check("wr_ready_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
         ai = a + AW'(i);
         ref_mem[ai] = wq[i];
         if (i + 1 < n) wr_data = wq[i+1];
      end
      wr_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("wr_en_count", 64'(wr_en_cnt), 64'(n));
      check("wr_first_latency", 64'(first_wr_cyc - cmd_cyc), 64'd2);
      check("wr_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'(n - 1));
      check("wr_done_count", 64'(done_cnt), 64'd1);
      check("wr_done_timing", 64'(done_cyc - last_wr_cyc), 64'd1);
      check("wr_addr_log_size", 64'(wr_addr_log.size()), 64'(n));
      for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
         ai = a + AW'(i);
         check("wr_addr", 64'(wr_addr_log[i]), 64'(ai));
         check("wr_mem", mem[ai], ref_mem[ai]);
      end
   endtask

   task automatic run_read(input logic [AW-1:0] a, input int n, input int stall_lo,
                           input int stall_hi, input logic stalled);
      int rel;
      int t;
      clear_stats();
      rd_ready = 1'b1;
      for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[a + AW'(i)]);
      issue_cmd(1'b0, a, LW'(n));
      for (t = 0; t < 300 && pops < n; t++) begin
         @(posedge clk); #1;
         rel = cyc - cmd_cyc;
         rd_ready = !(rel >= stall_lo && rel <= stall_hi);
      end
      if (t == 300) check("rd_timeout", 64'd0, 64'd1);
      rd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rd_words_left", 64'(exp_q.size()), 64'd0);
      check("rd_pop_count", 64'(pops), 64'(n));
      check("rd_issue_count", 64'(rd_issue_cnt), 64'(n));
      check("rd_first_valid_latency", 64'(first_rdv_cyc - cmd_cyc), 64'd4);
      check("rd_done_count", 64'(done_cnt), 64'd1);
      check("rd_done_timing", 64'(done_cyc - last_pop_cyc), 64'd1);
      if (stalled) check("rd_stall_occupancy", 64'(max_out), 64'd4);
      else begin
         check("rd_occupancy_bound", 64'(max_out <= 4), 64'd1);
         check("rd_back_to_back", 64'(last_pop_cyc - first_pop_cyc), 64'(n - 1));
      end
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_ram_en", 64'(ram_bus.en), 64'd0);
      check("rst_ram_addr", 64'(ram_bus.addr), 64'd0);
      check("rst_ram_wdata", ram_bus.wdata, 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // Write then read back four words.
      wq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
      run_write(10'h010, 4);
      run_read(10'h010, 4, 1000, 1000, 1'b0);

      // Address wrap across the top of the RAM, both directions.
      wq = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
      run_write(10'h3FE, 4);
      check("wrap_mem_000", mem[10'h000], 64'hB2);
      check("wrap_mem_001", mem[10'h001], 64'hB3);
      run_read(10'h3FE, 4, 1000, 1000, 1'b0);

      // Eight-word read with the consumer stalled for relative cycles 4..10.
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back({$urandom, $urandom});
      run_write(10'h020, 8);
      run_read(10'h020, 8, 4, 10, 1'b1);

      // Zero-length command.
      clear_stats();
      issue_cmd(1'b1, 10'h055, '0);
      @(negedge clk);
      check("len0_done_pulse", 64'(done), 64'd1);
      check("len0_cmd_ready", 64'(cmd_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("len0_no_ram_access", 64'(wr_en_cnt + rd_issue_cnt), 64'd0);
      check("len0_done_count", 64'(done_cnt), 64'd1);

      // Reset in the middle of a read burst.
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back({$urandom, $urandom});
      run_write(10'h040, 8);
      clear_stats();
      rd_ready = 1'b0;
      issue_cmd(1'b0, 10'h040, LW'(8));
      for (t = 0; t < 50; t++) begin
         if (rd_issue_cnt >= 3) break;
         @(negedge clk);
      end
      if (t == 50) check("abort_issue_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("abort_ram_en", 64'(ram_bus.en), 64'd0);
      check("abort_ram_we", 64'(ram_bus.we), 64'd0);
      check("abort_ram_addr", 64'(ram_bus.addr), 64'd0);
      check("abort_rd_valid", 64'(rd_valid), 64'd0);
      check("abort_wr_ready", 64'(wr_ready), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'd0);
      run_read(10'h040, 4, 1000, 1000, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
